// File: rtl/scpad_xbar_unswizzle.sv
// ---------------------------------------------------------------------------
// scpad_xbar_unswizzle
//
// Read-side consumer of the scratchpad swizzle descriptor. It turns each
// accepted descriptor into one cycle of per-bank read enables and row
// addresses. It then collects the bank beats, which return in issue order,
// and un-swizzles each beat back into logical lane order. The result is
// presented on a valid/ready output stream.
//
// Optional build macro:
//   SCPAD_UNSWIZZLE_ERR_EN  adds the sticky 2-bit err port {conflict, spurious}
//                           and its detection logic.
//
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   desc_valid/ready      descriptor handshake
//   desc                  {slot_mask, shift_mask, valid_mask}, lane-packed
//   bank_ren              per-bank read enable, one cycle per accept
//   bank_raddr            per-bank row address, held between issues
//   bank_rvalid/rdata     one in-order beat of bank data
//   out_valid/ready       output handshake
//   out_data, out_mask    lanes in logical order plus the lane valid mask
//   err                   {conflict, spurious}, only with SCPAD_UNSWIZZLE_ERR_EN
// ---------------------------------------------------------------------------
module scpad_xbar_unswizzle #(
  parameter int NUM_COLS = 32,
  parameter int COL_W    = $clog2(NUM_COLS),
  parameter int ROW_W    = 8,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4   // power of 2, at least 2
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               desc_valid,
  output logic                               desc_ready,
  input  logic [NUM_COLS*(ROW_W+COL_W+1)-1:0] desc,
  output logic [NUM_COLS-1:0]                bank_ren,
  output logic [NUM_COLS*ROW_W-1:0]          bank_raddr,
  input  logic                               bank_rvalid,
  input  logic [NUM_COLS*DATA_W-1:0]         bank_rdata,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_COLS*DATA_W-1:0]         out_data,
  output logic [NUM_COLS-1:0]                out_mask
`ifdef SCPAD_UNSWIZZLE_ERR_EN
  ,
  output logic [1:0]                         err
`endif
);

  localparam int SHIFT_W = NUM_COLS * COL_W;
  localparam int SLOT_W  = NUM_COLS * ROW_W;
  localparam int LANE_W  = NUM_COLS * DATA_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Bank index held in lane c of a packed shift mask.
  function automatic int unsigned shift_of(input logic [SHIFT_W-1:0] sm, input int c);
    return 32'(sm[c*COL_W +: COL_W]);
  endfunction

  // -------------------------------------------------------------------------
  // Descriptor fields
  // -------------------------------------------------------------------------
  logic [NUM_COLS-1:0] d_valid;
  logic [SHIFT_W-1:0]  d_shift;
  logic [SLOT_W-1:0]   d_slot;

  assign d_valid = desc[NUM_COLS-1:0];
  assign d_shift = desc[NUM_COLS +: SHIFT_W];
  assign d_slot  = desc[NUM_COLS+SHIFT_W +: SLOT_W];

  // -------------------------------------------------------------------------
  // Handshakes and outstanding bound
  // -------------------------------------------------------------------------
  logic             accept;
  logic             out_pop;
  logic [CNT_W-1:0] outstanding;

  // desc_ready depends only on the counter register. out_ready does not
  // reach it combinationally, so a freed slot shows up one cycle after the pop.
  assign desc_ready = (outstanding < CNT_W'(DEPTH));
  assign accept     = desc_valid && desc_ready;
  assign out_pop    = out_valid && out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      outstanding <= '0;
    end else begin
      case ({accept, out_pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Issue: per-bank enable and address, the lowest-index lane wins a bank
  // -------------------------------------------------------------------------
  logic [NUM_COLS-1:0] ren_nxt;
  logic [SLOT_W-1:0]   raddr_nxt;
`ifdef SCPAD_UNSWIZZLE_ERR_EN
  logic                conflict_nxt;
`endif

  // Lanes are scanned upward. The first valid lane to claim a bank sets the
  // address. A later lane on the same bank is either a broadcast (same
  // slot, legal) or a conflict (different slot, flagged and ignored).
  always_comb begin
    ren_nxt   = '0;
    raddr_nxt = '0;
`ifdef SCPAD_UNSWIZZLE_ERR_EN
    conflict_nxt = 1'b0;
`endif
    for (int c = 0; c < NUM_COLS; c++) begin
      if (d_valid[c]) begin
        if (!ren_nxt[shift_of(d_shift, c)]) begin
          ren_nxt[shift_of(d_shift, c)] = 1'b1;
          raddr_nxt[shift_of(d_shift, c)*ROW_W +: ROW_W] = d_slot[c*ROW_W +: ROW_W];
        end
`ifdef SCPAD_UNSWIZZLE_ERR_EN
        else if (raddr_nxt[shift_of(d_shift, c)*ROW_W +: ROW_W] != d_slot[c*ROW_W +: ROW_W]) begin
          conflict_nxt = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_ren   <= '0;
      bank_raddr <= '0;
    end else begin
      bank_ren <= accept ? ren_nxt : '0;
      if (accept) begin
        bank_raddr <= raddr_nxt;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Descriptor FIFO: {shift_mask, valid_mask} of each issued vector, waiting
  // for its beat. It cannot overflow because entries never exceed the
  // outstanding count.
  // -------------------------------------------------------------------------
  logic [SHIFT_W-1:0]  dq_shift [DEPTH];
  logic [NUM_COLS-1:0] dq_valid [DEPTH];
  logic [PTR_W:0]      dq_wr;
  logic [PTR_W:0]      dq_rd;
  logic                dq_empty;
  logic                dq_pop;
  logic [SHIFT_W-1:0]  head_shift;
  logic [NUM_COLS-1:0] head_valid;

  assign dq_empty   = (dq_wr == dq_rd);
  assign dq_pop     = bank_rvalid && !dq_empty;
  assign head_shift = dq_shift[dq_rd[PTR_W-1:0]];
  assign head_valid = dq_valid[dq_rd[PTR_W-1:0]];

  always_ff @(posedge CLK) begin
    if (accept) begin
      dq_shift[dq_wr[PTR_W-1:0]] <= d_shift;
      dq_valid[dq_wr[PTR_W-1:0]] <= d_valid;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dq_wr <= '0;
      dq_rd <= '0;
    end else begin
      if (accept) begin
        dq_wr <= dq_wr + 1'b1;
      end
      if (dq_pop) begin
        dq_rd <= dq_rd + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Remap: lane c takes the word of bank shift[c]. Invalid lanes are zeroed.
  // -------------------------------------------------------------------------
  logic [LANE_W-1:0] lane_nxt;

  always_comb begin
    lane_nxt = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (head_valid[c]) begin
        lane_nxt[c*DATA_W +: DATA_W] = bank_rdata[shift_of(head_shift, c)*DATA_W +: DATA_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data FIFO: un-swizzled vectors awaiting the output handshake. It cannot
  // overflow because entries never exceed the outstanding count.
  // -------------------------------------------------------------------------
  logic [LANE_W-1:0]   df_data [DEPTH];
  logic [NUM_COLS-1:0] df_mask [DEPTH];
  logic [PTR_W:0]      df_wr;
  logic [PTR_W:0]      df_rd;

  always_ff @(posedge CLK) begin
    if (dq_pop) begin
      df_data[df_wr[PTR_W-1:0]] <= lane_nxt;
      df_mask[df_wr[PTR_W-1:0]] <= head_valid;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      df_wr <= '0;
      df_rd <= '0;
    end else begin
      if (dq_pop) begin
        df_wr <= df_wr + 1'b1;
      end
      if (out_pop) begin
        df_rd <= df_rd + 1'b1;
      end
    end
  end

  assign out_valid = (df_wr != df_rd);

  // The storage has no reset. The head is gated so that out_data/out_mask
  // read zero when empty, both after reset and after draining.
  assign out_data = out_valid ? df_data[df_rd[PTR_W-1:0]] : '0;
  assign out_mask = out_valid ? df_mask[df_rd[PTR_W-1:0]] : '0;

  // -------------------------------------------------------------------------
  // Sticky error flags
  // -------------------------------------------------------------------------
`ifdef SCPAD_UNSWIZZLE_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 2'b00;
    end else begin
      if (accept && conflict_nxt) begin
        err_q[1] <= 1'b1;
      end
      if (bank_rvalid && dq_empty) begin
        err_q[0] <= 1'b1;
      end
    end
  end

  assign err = err_q;
`endif

endmodule
